// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
// No logic; state encoding and word/lane geometry only.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ACCEPT = 3'd2,
        S_WRITE  = 3'd3,
        S_FIN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_word.sv
// Word-to-byte serializer: holds one stream word and emits it low byte first.
// Byte/lane valid the cycle after load; never stalls, advance is owned by the caller.
module imem_word_serializer
    import imem_loader_pkg::*;
#(
    parameter int CELL_W = 8
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic                             advance,
    input  logic [BYTES_PER_WORD*CELL_W-1:0] word,
    output logic [CELL_W-1:0]                byte_dat,
    output logic [LANE_W-1:0]                lane,
    output logic                             last
);

    logic [BYTES_PER_WORD*CELL_W-1:0] hold_q;
    logic [LANE_W-1:0]                lane_q;

    // Shifting right keeps the current byte in the low cell, so byte_dat is a plain flop tap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            lane_q <= '0;
        end else if (load) begin
            hold_q <= word;
            lane_q <= '0;
        end else if (advance) begin
            hold_q <= hold_q >> CELL_W;
            lane_q <= lane_q + LANE_W'(1);
        end
    end

    assign byte_dat = hold_q[CELL_W-1:0];
    assign lane     = lane_q;
    assign last     = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams 32-bit words into byte-wide imem, little-endian, holding the CPU meanwhile.
// 5 cycles/word min; in_ready only while waiting for a word. Optional IMEM_LOADER_CHECKSUM_EN adds a word checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int WORD_SIZE     = 32,
    parameter  int MEM_SIZE      = 1024,
    parameter  int MEM_CELL_SIZE = 8,
    localparam int AW            = $clog2(MEM_SIZE),
    localparam int CW            = $clog2(MEM_SIZE/4) + 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AW-1:0]            base_addr,
    input  logic [CW-1:0]            word_count,
    input  logic                     in_valid,
    input  logic [WORD_SIZE-1:0]     in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,output logic [WORD_SIZE-1:0]    checksum
`endif
);

    localparam int RW = AW + CW + 1;

    state_t                   state, next_state;
    logic [AW-1:0]            addr_q;
    logic [CW-1:0]            remaining;
    logic [RW-1:0]            load_end;
    logic                     align_bad, range_bad;
    logic                     accept;
    logic                     ser_last;
    logic [LANE_W-1:0]        ser_lane;
    logic [MEM_CELL_SIZE-1:0] ser_byte;

    assign accept    = in_ready && in_valid;
    assign load_end  = RW'(addr_q) + (RW'(remaining) << LANE_W);
    assign align_bad = (addr_q[LANE_W-1:0] != '0);
    assign range_bad = (load_end > RW'(MEM_SIZE));

    imem_word_serializer #(
        .CELL_W (MEM_CELL_SIZE)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (state == S_WRITE),
        .word     (in_data),
        .byte_dat (ser_byte),
        .lane     (ser_lane),
        .last     (ser_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_CHECK;
            S_CHECK: begin
                if (align_bad || range_bad) next_state = S_ERR;
                else if (remaining == '0)   next_state = S_FIN;
                else                        next_state = S_ACCEPT;
            end
            S_ACCEPT: if (in_valid) next_state = S_WRITE;
            S_WRITE: begin
                if (ser_last) next_state = (remaining == CW'(1)) ? S_FIN : S_ACCEPT;
            end
            S_FIN:    next_state = S_IDLE;
            S_ERR:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_ACCEPT);
        cpu_hold = (state != S_IDLE);
    end

    // addr_q stays word-aligned through a load; the lane supplies the low address bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            remaining <= '0;
        end else if (state == S_IDLE && start) begin
            addr_q    <= base_addr;
            remaining <= word_count;
        end else if (state == S_WRITE && ser_last) begin
            addr_q    <= addr_q + AW'(BYTES_PER_WORD);
            remaining <= remaining - CW'(1);
        end
    end

    // Strobes are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            mem_we <= (next_state == S_WRITE);
            done   <= (next_state == S_FIN);
            error  <= (next_state == S_ERR);
        end
    end

    assign mem_addr  = {addr_q[AW-1:LANE_W], ser_lane};
    assign mem_wdata = ser_byte;

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          checksum <= '0;
        else if (state == S_IDLE && start) checksum <= '0;
        else if (accept)                   checksum <= checksum + in_data;
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver queues expected byte writes and end events,
// a negedge monitor pops and compares them and mirrors the written memory image.
module tb_imem_loader;

    localparam int MEM_SIZE = 1024;
    localparam int AW       = 10;
    localparam int CW       = 9;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        bit          is_err;
        bit          had_writes;
        logic [31:0] csum;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready, mem_we, cpu_hold, done, error;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    wr_t         wr_q[$];
    ev_t         ev_q[$];
    logic [31:0] wq[$];
    logic [7:0]  tb_mem[MEM_SIZE];
    logic [7:0]  ref_mem[MEM_SIZE];
    int          total = 0;
    int          bad   = 0;
    bit          ready_seen;
    logic        prev_we;
    wr_t         mon_wr;
    ev_t         mon_ev;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,.checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT writes or ends a request.
    always @(negedge clk) begin
        if (!rst) begin
            prev_we = 1'b0;
        end else begin
            if (in_ready) ready_seen = 1'b1;
            if (mem_we) begin
                tb_mem[mem_addr] = mem_wdata;
                if (wr_q.size() == 0) check("spurious_write", 1, 0);
                else begin
                    mon_wr = wr_q.pop_front();
                    check("wr_addr", mem_addr, mon_wr.addr);
                    check("wr_data", mem_wdata, mon_wr.data);
                end
            end
            if (in_ready || mem_we || done || error) begin
                check("hold_while_busy", cpu_hold, 1);
                check("ready_exclusive", in_ready & (mem_we | done | error), 0);
            end
            if (done || error) begin
                if (ev_q.size() == 0) check("spurious_end", 1, 0);
                else begin
                    mon_ev = ev_q.pop_front();
                    check("end_is_error", error, mon_ev.is_err);
                    check("end_is_done", done, !mon_ev.is_err);
                    if (done && mon_ev.had_writes) check("done_after_last_we", prev_we, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (done) check("checksum", checksum, mon_ev.csum);
`endif
                end
            end
            prev_we = mem_we;
        end
    end

    task automatic pulse_start(input int base, input int cnt);
        base_addr  = AW'(base);
        word_count = CW'(cnt);
        start      = 1'b1;
        ready_seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_in_check", cpu_hold, 1);
        check("ready_in_check", in_ready, 0);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check(name, 0, 1);
    endtask

    task automatic wait_end();
        int n = 0;
        while (ev_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (ev_q.size() != 0) begin
            check("end_timeout", ev_q.size(), 0);
            ev_q.delete();
        end else begin
            check("hold_release", cpu_hold, 0);
            check("pulse_one_cycle", done | error, 0);
        end
        check("writes_drained", wr_q.size(), 0);
        wr_q.delete();
    endtask

    // Expected outcome comes straight from the load rules: aligned and fits in memory.
    task automatic run_load(input int base, input int cnt, input int smin, input int smax, input bit poke);
        bit          ok;
        logic [31:0] w;
        logic [31:0] sum = 0;
        ev_t         ev;
        int          stall;
        ok = (base % 4 == 0) && (base + 4 * cnt <= MEM_SIZE);
        if (ok) begin
            for (int i = 0; i < cnt; i++) begin
                w = wq[i];
                sum += w;
                for (int j = 0; j < 4; j++) wr_q.push_back({AW'(base + 4 * i + j), w[8*j +: 8]});
            end
        end
        ev.is_err = !ok; ev.had_writes = ok && (cnt > 0); ev.csum = sum;
        ev_q.push_back(ev);
        pulse_start(base, cnt);
        if (!ok || cnt == 0) begin
            @(posedge clk); #1;
            check(ok ? "zero_done_timing" : "reject_err_timing", ok ? done : error, 1);
        end else begin
            for (int i = 0; i < cnt; i++) begin
                stall = $urandom_range(smax, smin);
                if (stall == 0) begin
                    in_valid = 1'b1; in_data = wq[i];
                    wait_ready("ready_timeout");
                end else begin
                    wait_ready("ready_timeout");
                    repeat (stall) begin @(posedge clk); #1; end
                    check("ready_held_in_stall", in_ready, 1);
                    in_valid = 1'b1; in_data = wq[i];
                end
                @(posedge clk); #1;
                in_valid = 1'b0; in_data = $urandom;
                if (poke && i == 0) begin
                    base_addr = '0; word_count = CW'(1); start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
        end
        wait_end();
        if (!ok || cnt == 0) check("no_ready_seen", ready_seen, 0);
        if (ok)
            for (int i = 0; i < cnt; i++)
                for (int j = 0; j < 4; j++) begin
                    w = wq[i];
                    ref_mem[base + 4 * i + j] = w[8*j +: 8];
                end
    endtask

    task automatic fill_words(input int cnt);
        wq.delete();
        for (int i = 0; i < cnt; i++) wq.push_back($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          nmis, cnt, base;
        for (int i = 0; i < MEM_SIZE; i++) begin tb_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; base_addr = '0; word_count = '0;
        #23;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        @(posedge clk); #1 rst = 1'b1;

        wq.delete(); wq.push_back(32'h8020000A);
        run_load(0, 1, 0, 0, 0);
        check("fetch_addr0", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h8020000A);

        fill_words(3);
        run_load(16, 3, 2, 2, 0);

        run_load(2, 1, 0, 0, 0);
        fill_words(2);
        run_load(1020, 2, 0, 0, 0);
        fill_words(2);
        run_load(1016, 2, 0, 1, 0);
        run_load(32, 0, 0, 0, 0);

        // Reset in the middle of word 1, right after its second byte lands.
        w = $urandom;
        wr_q.push_back({AW'(0), w[7:0]});
        wr_q.push_back({AW'(1), w[15:8]});
        pulse_start(0, 2);
        in_valid = 1'b1; in_data = w;
        wait_ready("ready_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #6;
        rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_cpu_hold", cpu_hold, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_bytes_written", wr_q.size(), 0);
        wr_q.delete();
        ref_mem[0] = w[7:0]; ref_mem[1] = w[15:8];
        check("arst_keep_mem0", tb_mem[0], w[7:0]);
        check("arst_keep_mem1", tb_mem[1], w[15:8]);
        @(posedge clk); #1 rst = 1'b1;
        fill_words(1);
        run_load(200, 1, 0, 2, 0);

        wq.delete(); wq.push_back(32'h1); wq.push_back(32'h2); wq.push_back(32'hFFFFFFFF);
        run_load(64, 3, 0, 0, 1);

        for (int k = 0; k < 16; k++) begin
            cnt = $urandom_range(4, 1);
            if (k % 4 == 3) base = $urandom_range(MEM_SIZE - 1, 0);
            else            base = 4 * $urandom_range(MEM_SIZE / 4 - cnt, 0);
            fill_words(cnt);
            run_load(base, cnt, 0, 3, 0);
        end

        nmis = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (tb_mem[i] !== ref_mem[i]) nmis++;
        check("mem_image", nmis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time controller that fills the byte-wide instruction memory from a 32-bit word stream before the pipeline runs. It accepts words over a valid/ready handshake and splits each into four byte writes in little-endian order, matching the fetch assembly {mem[a+3],mem[a+2],mem[a+1],mem[a]}. It holds the CPU (cpu_hold) for the whole load. It replaces the hard-coded reset contents of instruction memory.

Parameters:
WORD_SIZE, 32, instruction/stream word width
MEM_SIZE, 1024, instruction memory size in bytes (power of 2)
MEM_CELL_SIZE, 8, memory cell width; WORD_SIZE = 4*MEM_CELL_SIZE required
AW, $clog2(MEM_SIZE), derived byte address width (localparam)
CW, $clog2(MEM_SIZE/4)+1, derived word count width (localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle request to begin a load; sampled only in IDLE
base_addr  in  AW  first byte address of the load
word_count  in  CW  number of 32-bit words to load
in_valid  in  1  stream word valid
in_data  in  WORD_SIZE  stream word
in_ready  out  1  loader can accept in_data this cycle
mem_we  out  1  byte write strobe to instruction memory
mem_addr  out  AW  byte write address
mem_wdata  out  MEM_CELL_SIZE  byte write data
cpu_hold  out  1  stall/hold pipeline while loading
done  out  1  one-cycle pulse, load completed successfully
error  out  1  one-cycle pulse, load rejected

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready, mem_we, cpu_hold, done, error = 0; mem_addr, mem_wdata = 0; counters cleared. Memory contents are not touched. Reset during a load abandons it, and bytes already written stay written.
- States: IDLE, CHECK, ACCEPT, WRITE, FIN, ERR.
- IDLE: start=1 -> latch base_addr and word_count -> CHECK. Otherwise stay in IDLE. cpu_hold=0.
- CHECK (1 cycle, cpu_hold=1):
  - base_addr[1:0]!=0, or base_addr + 4*word_count > MEM_SIZE (computed at AW+CW+1 bits, no wrap) -> ERR.
  - word_count==0 -> FIN.
  - Otherwise -> ACCEPT.
- ACCEPT: in_ready=1. When in_valid&&in_ready, capture in_data and go to WRITE with lane=0. in_valid may stall indefinitely.
- WRITE (4 cycles, in_ready=0): mem_we=1, mem_addr=cur_addr+lane, mem_wdata=word[8*lane+7:8*lane] for lane 0..3.
  - After lane 3: cur_addr+=4, remaining-=1.
  - remaining becomes 0 -> FIN; otherwise -> ACCEPT.
- Throughput: 5 cycles per word minimum. Address never wraps because CHECK guarantees the range.
- FIN: done=1 for one cycle, cpu_hold=1, then IDLE. cpu_hold deasserts the cycle after FIN.
- ERR: error=1 for one cycle, no mem_we at any time in the request, then IDLE.
- start while not IDLE: ignored. in_valid outside ACCEPT: ignored, data not consumed.
- cpu_hold=1 in every state except IDLE.
- All outputs are registered, except in_ready and cpu_hold, which are decoded from the state register.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN:
- Defined: adds output port checksum [WORD_SIZE-1:0].
  - Cleared to 0 on reset and on entry to CHECK.
  - Adds each accepted in_data modulo 2^WORD_SIZE.
  - Stable and valid while done=1, and holds its value until the next start.
- Not defined: no checksum port or logic. All other behaviour is identical.

Decomposition:
- Package imem_loader_pkg holds:
  - state encoding constants (IDLE..ERR, 3-bit);
  - BYTES_PER_WORD=4;
  - LANE_W=2.
- One natural sub-module, imem_word_serializer:
  - 32-bit holding register plus 2-bit lane counter;
  - inputs load/word, outputs byte/lane/last;
  - driven by the imem_loader FSM.

Test Plan:
1. Basic load: reset, then start with base_addr=0, word_count=1, in_data=32'h8020000A.
   - Required writes in order: mem[0]=0A, mem[1]=00, mem[2]=20, mem[3]=80.
   - done pulses exactly 1 cycle after the last write.
   - Fetch at addr 0 reads 8020000A.
2. Multi-word with stalls: base=16, count=3, in_valid low 2 cycles between words.
   - Writes land at bytes 16..27.
   - in_ready is high only in ACCEPT.
   - cpu_hold stays high from the cycle after start through FIN.
3. Rejects: base=2 -> error pulse, zero mem_we. Base=1020 with count=2 -> error pulse, zero mem_we. Base=1016 with count=2 -> accepted, last write at 1023.
4. Zero count: count=0 -> done one cycle after CHECK, no mem_we, no in_ready.
5. Async reset after the 2nd byte of word 1 (load base=0):
   - Outputs clear immediately, without waiting for a clock edge.
   - mem[0..1] keep the new data.
   - A following start completes normally.
6. start pulsed during WRITE is ignored and no second done occurs. With IMEM_LOADER_CHECKSUM_EN defined, words 1,2,FFFFFFFF give checksum=00000002 at done.
